// File: rtl/race_start_sequencer.sv
// race_start_sequencer
//
// Christmas-tree race start controller for multiple lanes. An internal prescaler produces a
// tick every DIV = CLK_HZ/TICK_HZ cycles, so everything runs in the CLOCK domain. A rising edge
// on START runs RED_HOLD -> YEL(0..NUM_YELLOW-1) -> GO -> IDLE. A lane departing before GO
// latches its FOUL bit and parks the block in FAULT until the next start edge. ABORT returns
// to IDLE from anywhere.
//
// Ports:
//   CLOCK    system clock, rising edge
//   nRESET   asynchronous active-low reset
//   START    level input, rising edge starts a sequence (already synchronised)
//   ABORT    synchronous abort, active-high
//   LANE_GO  per-lane departure sensors, active-high
//   RED      red lamp
//   YELLOW   yellow lamps, thermometer coded
//   GREEN    green lamp
//   FOUL     latched per-lane false-start flags
//   BUSY     high in RED_HOLD, YEL and GO
module race_start_sequencer #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TICK_HZ     = 1,
    parameter int unsigned NUM_YELLOW  = 3,
    parameter int unsigned RED_TICKS   = 2,
    parameter int unsigned GREEN_TICKS = 5,
    parameter int unsigned NUM_LANES   = 2
) (
    input  logic                  CLOCK,
    input  logic                  nRESET,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [NUM_LANES-1:0]  LANE_GO,
    output logic                  RED,
    output logic [NUM_YELLOW-1:0] YELLOW,
    output logic                  GREEN,
    output logic [NUM_LANES-1:0]  FOUL,
    output logic                  BUSY
);

    localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
    localparam int unsigned PW        = $clog2(DIV);
    localparam int unsigned MAX_TICKS = (RED_TICKS > GREEN_TICKS) ? RED_TICKS : GREEN_TICKS;
    localparam int unsigned SW        = $clog2(MAX_TICKS + 1);
    localparam int unsigned YW        = (NUM_YELLOW > 1) ? $clog2(NUM_YELLOW) : 1;

    localparam logic [PW-1:0] DivLast   = PW'(DIV - 1);
    localparam logic [SW-1:0] RedLast   = SW'(RED_TICKS - 1);
    localparam logic [SW-1:0] GreenLast = SW'(GREEN_TICKS - 1);
    localparam logic [YW-1:0] YelLast   = YW'(NUM_YELLOW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRedHold,
        StYel,
        StGo,
        StFault
    } state_e;

    state_e                  state_q, state_d;
    logic [YW-1:0]           yel_q, yel_d;
    logic [SW-1:0]           stage_q, stage_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic                    start_q;
    logic [NUM_LANES-1:0]    foul_q, foul_d;
    logic                    red_q, red_d;
    logic [NUM_YELLOW-1:0]   yellow_q, yellow_d;
    logic                    green_q, green_d;
    logic                    busy_q, busy_d;

    logic tick;
    logic start_ev;
    logic lane_any;

    assign tick     = (presc_q == DivLast);
    assign start_ev = START & ~start_q;
    assign lane_any = |LANE_GO;

    // Next-state logic. Priority: ABORT > foul > tick advance > start event.
    always_comb begin
        state_d = state_q;
        yel_d   = yel_q;
        stage_d = stage_q;
        presc_d = presc_q;
        foul_d  = foul_q;

        // Prescaler only runs in the tick-timed states.
        if (state_q inside {StRedHold, StYel, StGo}) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (ABORT) begin
            state_d = StIdle;
            foul_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StFault: begin
                    if (start_ev) begin
                        state_d = StRedHold;
                        foul_d  = '0;
                    end
                end
                StRedHold: begin
                    if (lane_any) begin
                        state_d = StFault;
                        foul_d  = foul_q | LANE_GO;
                    end else if (tick) begin
                        if (stage_q == RedLast) begin
                            state_d = StYel;
                            yel_d   = '0;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end
                end
                StYel: begin
                    // A foul on the final yellow tick cycle still beats the move to GO.
                    if (lane_any) begin
                        state_d = StFault;
                        foul_d  = foul_q | LANE_GO;
                    end else if (tick) begin
                        if (yel_q == YelLast) begin
                            state_d = StGo;
                        end else begin
                            yel_d = yel_q + 1'b1;
                        end
                    end
                end
                StGo: begin
                    if (tick) begin
                        if (stage_q == GreenLast) begin
                            state_d = StIdle;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    foul_d  = '0;
                end
            endcase
        end

        // Every state entry restarts stage timing from zero.
        if (state_d != state_q) begin
            presc_d = '0;
            stage_d = '0;
        end
    end

    // Moore outputs decoded from the next state so the registered lamps line up with state_q.
    always_comb begin
        red_d    = (state_d == StIdle) || (state_d == StRedHold) || (state_d == StFault);
        green_d  = (state_d == StGo);
        busy_d   = (state_d == StRedHold) || (state_d == StYel) || (state_d == StGo);
        yellow_d = '0;
        for (int unsigned i = 0; i < NUM_YELLOW; i++) begin
            yellow_d[i] = (state_d == StYel) && (YW'(i) <= yel_d);
        end
    end

    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= StIdle;
            yel_q    <= '0;
            stage_q  <= '0;
            presc_q  <= '0;
            start_q  <= 1'b0;
            foul_q   <= '0;
            red_q    <= 1'b1;
            yellow_q <= '0;
            green_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            yel_q    <= yel_d;
            stage_q  <= stage_d;
            presc_q  <= presc_d;
            start_q  <= START;
            foul_q   <= foul_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
            busy_q   <= busy_d;
        end
    end

    assign RED    = red_q;
    assign YELLOW = yellow_q;
    assign GREEN  = green_q;
    assign FOUL   = foul_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_race_start_sequencer.sv
// tb_race_start_sequencer
//
// Directed bench for race_start_sequencer with DIV=4, three yellows, RED_TICKS=2,
// GREEN_TICKS=3 and two lanes. A timeline model (elapsed cycles since the start edge) predicts
// all outputs every cycle; literal checks at hand-picked cycles pin that model.
module tb_race_start_sequencer;

    localparam int DV    = 4;
    localparam int NY    = 3;
    localparam int RT    = 2;
    localparam int GT    = 3;
    localparam int NL    = 2;
    localparam int TOTAL = (RT + NY + GT) * DV;

    logic          CLOCK;
    logic          nRESET;
    logic          START;
    logic          ABORT;
    logic [NL-1:0] LANE_GO;
    logic          RED;
    logic [NY-1:0] YELLOW;
    logic          GREEN;
    logic [NL-1:0] FOUL;
    logic          BUSY;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;
    int base     = 0;
    bit chk_en   = 1'b0;

    race_start_sequencer #(
        .CLK_HZ     (DV),
        .TICK_HZ    (1),
        .NUM_YELLOW (NY),
        .RED_TICKS  (RT),
        .GREEN_TICKS(GT),
        .NUM_LANES  (NL)
    ) dut (
        .CLOCK  (CLOCK),
        .nRESET (nRESET),
        .START  (START),
        .ABORT  (ABORT),
        .LANE_GO(LANE_GO),
        .RED    (RED),
        .YELLOW (YELLOW),
        .GREEN  (GREEN),
        .FOUL   (FOUL),
        .BUSY   (BUSY)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    // m_mode: 0 idle, 1 running, 2 fault. m_el counts cycles since the start edge.
    int            m_mode;
    int            m_el;
    logic [NL-1:0] m_foul;
    logic          m_start_q;

    always @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            m_mode    <= 0;
            m_el      <= 0;
            m_foul    <= '0;
            m_start_q <= 1'b0;
        end else begin
            m_start_q <= START;
            if (ABORT) begin
                m_mode <= 0;
                m_foul <= '0;
            end else if (m_mode == 1) begin
                if (m_el < (RT + NY) * DV && LANE_GO != '0) begin
                    m_mode <= 2;
                    m_foul <= LANE_GO;
                end else if (m_el + 1 == TOTAL) begin
                    m_mode <= 0;
                end else begin
                    m_el <= m_el + 1;
                end
            end else if (START && !m_start_q) begin
                m_mode <= 1;
                m_el   <= 0;
                m_foul <= '0;
            end
        end
    end

    function automatic void model_out(output logic r, output logic [NY-1:0] y,
                                      output logic g, output logic b);
        int k;
        r = 1'b1;
        y = '0;
        g = 1'b0;
        b = 1'b0;
        if (m_mode == 1) begin
            b = 1'b1;
            if (m_el >= RT * DV && m_el < (RT + NY) * DV) begin
                r = 1'b0;
                k = (m_el - RT * DV) / DV;
                y = NY'((1 << (k + 1)) - 1);
            end else if (m_el >= (RT + NY) * DV) begin
                r = 1'b0;
                g = 1'b1;
            end
        end
    endfunction

    always @(negedge CLOCK) begin
        logic          er;
        logic [NY-1:0] ey;
        logic          eg;
        logic          eb;
        if (chk_en) begin
            model_out(er, ey, eg, eb);
            chk("model_red", 32'(RED), 32'(er));
            chk("model_yellow", 32'(YELLOW), 32'(ey));
            chk("model_green", 32'(GREEN), 32'(eg));
            chk("model_busy", 32'(BUSY), 32'(eb));
            chk("model_foul", 32'(FOUL), 32'(m_foul));
        end
    end

    // ---------------- directed stimulus ----------------
    // Cycle c is the interval ending at edge c; inputs set in cycle c are sampled at edge c.
    task automatic new_test();
        base = edges;
    endtask

    task automatic at_cycle(input int c);
        while (edges - base + 1 < c) @(negedge CLOCK);
    endtask

    // Literal timing of a clean run whose start edge is sampled at cycle 10.
    task automatic check_clean(input string tag);
        at_cycle(11);
        chk({tag, "_c11_red"}, 32'(RED), 32'd1);
        chk({tag, "_c11_busy"}, 32'(BUSY), 32'd1);
        at_cycle(18);
        chk({tag, "_c18_yellow"}, 32'(YELLOW), 32'b000);
        at_cycle(19);
        chk({tag, "_c19_yellow"}, 32'(YELLOW), 32'b001);
        chk({tag, "_c19_red"}, 32'(RED), 32'd0);
        at_cycle(23);
        chk({tag, "_c23_yellow"}, 32'(YELLOW), 32'b011);
        at_cycle(27);
        chk({tag, "_c27_yellow"}, 32'(YELLOW), 32'b111);
        at_cycle(30);
        chk({tag, "_c30_green"}, 32'(GREEN), 32'd0);
        at_cycle(31);
        chk({tag, "_c31_green"}, 32'(GREEN), 32'd1);
        chk({tag, "_c31_yellow"}, 32'(YELLOW), 32'b000);
        at_cycle(42);
        chk({tag, "_c42_green"}, 32'(GREEN), 32'd1);
        chk({tag, "_c42_busy"}, 32'(BUSY), 32'd1);
        at_cycle(43);
        chk({tag, "_c43_red"}, 32'(RED), 32'd1);
        chk({tag, "_c43_green"}, 32'(GREEN), 32'd0);
        chk({tag, "_c43_busy"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        nRESET  = 1'b0;
        START   = 1'b0;
        ABORT   = 1'b0;
        LANE_GO = '0;
        repeat (3) @(negedge CLOCK);
        chk("reset_red", 32'(RED), 32'd1);
        chk("reset_yellow", 32'(YELLOW), 32'd0);
        chk("reset_green", 32'(GREEN), 32'd0);
        chk("reset_foul", 32'(FOUL), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        nRESET = 1'b1;
        chk_en = 1'b1;

        // Clean run
        new_test();
        at_cycle(10); START = 1'b1;
        at_cycle(12); START = 1'b0;
        check_clean("clean");

        // Foul in YEL(1), then restart out of FAULT
        new_test();
        at_cycle(10); START = 1'b1;
        at_cycle(12); START = 1'b0;
        at_cycle(24); LANE_GO = 2'b10;
        at_cycle(25); LANE_GO = 2'b00;
        chk("foul_c25_foul", 32'(FOUL), 32'b10);
        chk("foul_c25_red", 32'(RED), 32'd1);
        chk("foul_c25_yellow", 32'(YELLOW), 32'b000);
        chk("foul_c25_busy", 32'(BUSY), 32'd0);
        at_cycle(35);
        chk("foul_c35_held", 32'(FOUL), 32'b10);
        at_cycle(36); START = 1'b1;
        at_cycle(37);
        chk("foul_restart_foul", 32'(FOUL), 32'b00);
        chk("foul_restart_busy", 32'(BUSY), 32'd1);
        at_cycle(38); START = 1'b0;
        at_cycle(70);
        chk("foul_restart_done", 32'(BUSY), 32'd0);

        // Boundary foul on the last YEL(2) cycle, then legal departure in GO
        new_test();
        at_cycle(10); START = 1'b1;
        at_cycle(12); START = 1'b0;
        at_cycle(30); LANE_GO = 2'b11;
        at_cycle(31); LANE_GO = 2'b00;
        chk("bnd_c31_foul", 32'(FOUL), 32'b11);
        chk("bnd_c31_green", 32'(GREEN), 32'd0);
        at_cycle(40);
        chk("bnd_c40_green", 32'(GREEN), 32'd0);
        at_cycle(46); ABORT = 1'b1;
        at_cycle(47); ABORT = 1'b0;
        chk("bnd_abort_foul", 32'(FOUL), 32'b00);
        at_cycle(50); START = 1'b1;
        at_cycle(52); START = 1'b0;
        at_cycle(71); LANE_GO = 2'b11;
        at_cycle(72); LANE_GO = 2'b00;
        chk("go_lane_foul", 32'(FOUL), 32'b00);
        chk("go_lane_green", 32'(GREEN), 32'd1);
        at_cycle(85);

        // ABORT together with a foul in YEL(0)
        new_test();
        at_cycle(10); START = 1'b1;
        at_cycle(12); START = 1'b0;
        at_cycle(20); ABORT = 1'b1; LANE_GO = 2'b01;
        at_cycle(21); ABORT = 1'b0; LANE_GO = 2'b00;
        chk("abort_foul", 32'(FOUL), 32'b00);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_red", 32'(RED), 32'd1);
        chk("abort_yellow", 32'(YELLOW), 32'b000);
        at_cycle(25);

        // START held high across the end of a run
        new_test();
        at_cycle(10); START = 1'b1;
        at_cycle(43);
        chk("hold_c43_busy", 32'(BUSY), 32'd0);
        at_cycle(48);
        chk("hold_c48_busy", 32'(BUSY), 32'd0);
        chk("hold_c48_red", 32'(RED), 32'd1);
        at_cycle(50); START = 1'b0;

        // Mid-run START toggle is ignored
        new_test();
        at_cycle(10); START = 1'b1;
        at_cycle(14); START = 1'b0;
        at_cycle(15); START = 1'b1;
        check_clean("toggle");
        at_cycle(45); START = 1'b0;

        // Async reset during GO, then a clean run
        new_test();
        at_cycle(10); START = 1'b1;
        at_cycle(12); START = 1'b0;
        at_cycle(35);
        chk("areset_pre_green", 32'(GREEN), 32'd1);
        #2 nRESET = 1'b0;
        #1;
        chk("areset_red", 32'(RED), 32'd1);
        chk("areset_green", 32'(GREEN), 32'd0);
        chk("areset_foul", 32'(FOUL), 32'd0);
        chk("areset_busy", 32'(BUSY), 32'd0);
        at_cycle(37); nRESET = 1'b1;
        new_test();
        at_cycle(10); START = 1'b1;
        at_cycle(12); START = 1'b0;
        check_clean("post_reset");
        at_cycle(46);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/race_start_sequencer.md
Name: race_start_sequencer

Overview:
Parametrised successor to the fixed three-lamp race lights controller. It has an internal tick prescaler, so the whole block runs in one clock domain with no divided clock. It drives a configurable "christmas tree" of yellow stages and supports multiple lanes with per-lane false-start (foul) detection and an abort input. It sits directly under the board top and is fed by the 50 MHz board clock.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, sequence tick rate. DIV = CLK_HZ/TICK_HZ must be an integer of at least 2.
- NUM_YELLOW, 3, number of yellow stages, 1..8.
- RED_TICKS, 2, ticks RED is held after start, at least 1.
- GREEN_TICKS, 5, ticks GREEN is held, at least 1.
- NUM_LANES, 2, number of lanes monitored for fouls, 1..8.

Ports:
- CLOCK  in  1  system clock, rising edge.
- nRESET  in  1  asynchronous active-low reset.
- START  in  1  level input; a rising edge begins a sequence. Already synchronised upstream.
- ABORT  in  1  synchronous abort, active-high.
- LANE_GO  in  NUM_LANES  per-lane departure sensors, synchronous, active-high.
- RED  out  1  red lamp.
- YELLOW  out  NUM_YELLOW  yellow lamps, thermometer coded.
- GREEN  out  1  green lamp.
- FOUL  out  NUM_LANES  latched per-lane false-start flags.
- BUSY  out  1  high while in any state other than IDLE or FAULT.

Behaviour:
- Reset (async, nRESET=0):
  - State=IDLE, prescaler=0, start edge register=0.
  - Outputs: RED=1, YELLOW=0, GREEN=0, FOUL=0, BUSY=0.
  - Release is synchronous to the next rising edge of CLOCK.
- Start edge: start_q is a registered copy of START. A start event is START=1 and start_q=0.
- Prescaler:
  - Counts 0..DIV-1. tick is asserted when count==DIV-1, then the count wraps to 0.
  - Cleared to 0 on every state entry, so each tick-counted stage lasts exactly N*DIV cycles.
- Stage counter: counts ticks within the current stage. Width is clog2 of max(RED_TICKS, GREEN_TICKS)+1.
- All outputs are registered Moore outputs decoded from state.
- States and outputs:
  - IDLE: RED=1, YELLOW=0, GREEN=0. Start event -> RED_HOLD and FOUL cleared. LANE_GO is ignored.
  - RED_HOLD: RED=1. After RED_TICKS ticks -> YEL with k=0.
  - YEL(k): RED=0, YELLOW[k:0]=1, upper bits 0. After 1 tick: k<NUM_YELLOW-1 -> YEL(k+1); otherwise -> GO.
  - GO: GREEN=1, YELLOW=0, RED=0. After GREEN_TICKS ticks -> IDLE. LANE_GO is ignored (legal departure).
  - FAULT: RED=1, YELLOW=0, GREEN=0, FOUL held. Start event -> RED_HOLD with FOUL cleared.
- Foul rule: in RED_HOLD or any YEL state, any cycle with LANE_GO[i]=1 sets FOUL[i] on that edge and moves the state to FAULT. All lanes high in the same cycle are latched together. A foul in the last cycle of the final YEL (the same cycle as tick) still counts: foul wins over the advance to GO.
- ABORT=1 in any state -> IDLE next edge, FOUL cleared, prescaler cleared.
- Priority within a cycle: ABORT > foul > tick advance > start event.
- Start events while BUSY=1 are ignored. start_q still updates, so holding START high across the end of a sequence does not retrigger.
- Latency: a start event sampled at edge n gives state RED_HOLD after edge n. RED stays 1 and the first YELLOW bit rises at edge n+RED_TICKS*DIV.
- Total sequence length is (RED_TICKS+NUM_YELLOW+GREEN_TICKS)*DIV cycles.
- Reset asserted mid-sequence forces the reset values immediately, with no clock required.

Test Plan:
Bench parameters: CLK_HZ=4, TICK_HZ=1 (DIV=4), NUM_YELLOW=3, RED_TICKS=2, GREEN_TICKS=3, NUM_LANES=2.
- Clean run: START rises at cycle 10 -> RED 1 for cycles 11-18; YELLOW=001 at 19-22, 011 at 23-26, 111 at 27-30; GREEN=1 at 31-42; IDLE at 43 with RED=1; BUSY high for cycles 11-42.
- Foul: LANE_GO=10 at cycle 24 (in YEL(1)) -> FOUL=10, state FAULT, RED=1, YELLOW=000 from cycle 25; FAULT persists until the next START edge, which gives FOUL=00 and RED_HOLD.
- Boundary foul: LANE_GO=11 on the final cycle of YEL(2) (cycle 30) -> FOUL=11, GREEN never asserts. LANE_GO=11 at cycle 31 -> no foul, GREEN=1.
- ABORT at cycle 20 together with LANE_GO=01 -> IDLE at 21, FOUL=00, BUSY=0.
- Retrigger: START held high through the whole run -> returns to IDLE and stays. START toggled 1->0->1 at cycle 15 (mid-run) -> ignored, timing unchanged.
- Async reset: nRESET pulled low between edges during GO -> RED=1, GREEN=0, FOUL=0 before the next edge. After release, a START edge produces exact clean-run timing.
